// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Brief    : 1-to-N registered valid/ready demultiplexer with per-port
//            one-entry holding registers and a saturating bad-select counter.
// Revision : 1.0
// ============================================================================
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2,
    parameter int SEL_W = 1,
    parameter int ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       select,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [ERR_W-1:0]       err_count
);

    logic [N_OUT-1:0]       sel_hit;
    logic                   bad_sel;
    logic                   accept;

    logic [N_OUT-1:0]       valid_q, valid_d;
    logic [N_OUT*WIDTH-1:0] data_q,  data_d;
    logic [ERR_W-1:0]       err_q,   err_d;

    // One-hot decode; an out-of-range select leaves every bit clear.
    for (genvar i = 0; i < N_OUT; i++) begin : g_sel
        assign sel_hit[i] = (select == SEL_W'(i));
    end

    assign bad_sel  = ~|sel_hit;
    assign in_ready = ~|(sel_hit & valid_q & ~out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        for (int i = 0; i < N_OUT; i++) begin
            // A load wins over a drain so a full-and-draining slot refills in place.
            if (accept && sel_hit[i]) begin
                valid_d[i]                = 1'b1;
                data_d[i*WIDTH +: WIDTH] = in_data;
            end else if (valid_q[i] && out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (accept && bad_sel && !(&err_q)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux
// Brief    : Vector-table and scoreboard bench for stream_demux (2- and 3-port).
// Revision : 1.0
// ============================================================================
module tb_stream_demux;

    logic        clk;
    logic        reset;

    logic [7:0]  a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic        a_sel;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_valid;
    logic [1:0]  a_out_ready;
    logic [7:0]  a_err;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_sel;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [7:0]  b_err;

    stream_demux #(.WIDTH(8), .N_OUT(2), .SEL_W(1), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .select(a_sel),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_count(a_err)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .ERR_W(8)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .select(b_sel),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] sel;
        logic [7:0] data;
        logic [1:0] ordy;
        logic       exp_rdy;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sbq[2][$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic vld, input logic [1:0] sel,
                       input logic [7:0] data, input logic [1:0] ordy, input logic rdy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = sel; v.data = data; v.ordy = ordy; v.exp_rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // idle after reset, both selects
        add(0, 0, 0, 8'h00, 2'b11, 1);
        add(0, 0, 1, 8'h00, 2'b11, 1);
        // basic routing
        add(0, 1, 0, 8'hA5, 2'b11, 1);
        add(0, 1, 1, 8'h3C, 2'b11, 1);
        add(0, 0, 0, 8'h00, 2'b11, 1);
        add(0, 0, 0, 8'h00, 2'b11, 1);
        // backpressure isolation
        add(0, 1, 0, 8'h11, 2'b10, 1);
        add(0, 1, 0, 8'h22, 2'b10, 0);
        add(0, 1, 1, 8'h33, 2'b10, 1);
        add(0, 1, 0, 8'h22, 2'b11, 1);
        add(0, 0, 0, 8'h00, 2'b11, 1);
        // back-to-back streaming to port 1
        for (int i = 0; i < 8; i++) add(0, 1, 1, 8'(i), 2'b11, 1);
        add(0, 0, 1, 8'h00, 2'b11, 1);
        // reset while port 0 holds a stalled beat, with a same-cycle input beat
        add(0, 1, 0, 8'h5A, 2'b00, 1);
        add(0, 0, 0, 8'h00, 2'b00, 0);
        add(1, 1, 1, 8'h77, 2'b00, 1);
        add(0, 0, 1, 8'h00, 2'b00, 1);
        add(0, 0, 0, 8'h00, 2'b00, 1);

        reset = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_sel = 1'b0; a_out_ready = 2'b11;
        b_in_data = '0; b_in_valid = 1'b0; b_sel = 2'b00; b_out_ready = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #5;
        check("reset a_out_valid", 32'(a_out_valid), 0);
        check("reset a_out_data",  32'(a_out_data),  0);
        check("reset a_err",       32'(a_err),       0);
        check("reset b_out_valid", 32'(b_out_valid), 0);
        check("reset b_err",       32'(b_err),       0);
        tick();

        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            a_in_valid  = tbl[i].vld;
            a_sel       = tbl[i].sel[0];
            a_in_data   = tbl[i].data;
            a_out_ready = tbl[i].ordy;
            #5;
            check($sformatf("v%0d in_ready", i), 32'(a_in_ready), 32'(tbl[i].exp_rdy));
            check($sformatf("v%0d err", i), 32'(a_err), 0);
            for (int p = 0; p < 2; p++) begin
                check($sformatf("v%0d out_valid[%0d]", i, p), 32'(a_out_valid[p]),
                      32'(sbq[p].size() != 0));
                if (sbq[p].size() != 0) begin
                    check($sformatf("v%0d out_data[%0d]", i, p), 32'(a_out_data[p*8 +: 8]),
                          32'(sbq[p][0]));
                    if (tbl[i].ordy[p]) void'(sbq[p].pop_front());
                end
            end
            if (tbl[i].rst) begin
                sbq[0].delete();
                sbq[1].delete();
            end else if (tbl[i].vld && tbl[i].exp_rdy) begin
                sbq[tbl[i].sel[0]].push_back(tbl[i].data);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        a_in_valid = 1'b0;
        #5;
        check("post-reset a_out_data", 32'(a_out_data), 0);
        check("post-reset a_out_valid", 32'(a_out_valid), 0);

        // three-port instance: routing to port 2, then invalid selects
        b_sel = 2'd3;
        #1;
        check("b in_ready sel3 idle", 32'(b_in_ready), 1);
        b_in_valid = 1'b1; b_sel = 2'd2; b_in_data = 8'h9C;
        tick();
        b_in_valid = 1'b0;
        #5;
        check("b out_valid port2", 32'(b_out_valid), 32'b100);
        check("b out_data port2",  32'(b_out_data[23:16]), 32'h9C);
        check("b in_ready sel2 stalled", 32'(b_in_ready), 0);
        b_sel = 2'd3;
        #1;
        check("b in_ready sel3 stalled", 32'(b_in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_sel = 2'd3; b_in_data = 8'(8'hE0 + i);
            #1;
            check($sformatf("b bad-sel in_ready %0d", i), 32'(b_in_ready), 1);
            tick();
        end
        b_in_valid = 1'b0;
        #5;
        check("b err after 4",       32'(b_err), 4);
        check("b out_valid after 4", 32'(b_out_valid), 32'b100);
        check("b port2 held",        32'(b_out_data[23:16]), 32'h9C);
        b_in_valid = 1'b1;
        b_sel = 2'd3;
        repeat (300) tick();
        b_in_valid = 1'b0;
        #5;
        check("b err saturated", 32'(b_err), 32'hFF);
        check("b out_valid after 304", 32'(b_out_valid), 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
